inst_encoder: RTL and testbench

- Streams ALU operation descriptors (alu_control code, register numbers, immediate) in and emits 32-bit RV32I machine words with sequential instruction addresses.
- The inverse of the core's decode stage: it uses the same alu_control codes and is_unsigned flag.
- Feeds instruction-memory preload and self-check benches.
- A one-cycle encode stage sits in front of a small output FIFO.

---
 rtl/inst_encoder_pkg.sv | 41 ++++
 rtl/inst_encoder_if.sv | 36 +++
 rtl/inst_encoder_fifo.sv | 69 ++++++
 rtl/inst_encoder.sv | 170 +++++++++++++++++
 tb/tb_inst_encoder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_encoder_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg: shared constants for the RV32I instruction encoder.
//   - alu_control codes, which match the core's decode stage
//   - opcode, funct3 and funct7 field values
//   - the canonical nop word
//   - enc_result_t, the result of one encode operation
// Optional build macro used by this block: ENC_IMM_CHECK_EN (see inst_encoder.sv).
// ---------------------------------------------------------------------------
package enc_pkg;

  // alu_control codes
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // opcodes
  localparam logic [6:0] OPC_R = 7'h33;
  localparam logic [6:0] OPC_I = 7'h13;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;

  // funct7 values
  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic        illegal;
    logic [31:0] word;
  } enc_result_t;

endpackage

// File: rtl/inst_encoder_if.sv
// ---------------------------------------------------------------------------
// inst_encoder_if: descriptor-in / word-out bus of inst_encoder.
//   Producer side : in_valid, alu_control, is_unsigned, is_imm,
//                   rd_num, rs1_num, rs2_num, immSmall  -> in_ready
//   Consumer side : out_valid, inst, inst_addr, err     <- out_ready
// modport master : the bench or system that feeds and drains the encoder
// modport slave  : the encoder itself
// ---------------------------------------------------------------------------
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic        is_unsigned;
  logic        is_imm;
  logic [4:0]  rd_num;
  logic [4:0]  rs1_num;
  logic [4:0]  rs2_num;
  logic [31:0] immSmall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        err;

  modport master (
    output in_valid, alu_control, is_unsigned, is_imm,
           rd_num, rs1_num, rs2_num, immSmall, out_ready,
    input  in_ready, out_valid, inst, inst_addr, err
  );

  modport slave (
    input  in_valid, alu_control, is_unsigned, is_imm,
           rd_num, rs1_num, rs2_num, immSmall, out_ready,
    output in_ready, out_valid, inst, inst_addr, err
  );
endinterface

// File: rtl/inst_encoder_fifo.sv
// ---------------------------------------------------------------------------
// enc_fifo: small synchronous FIFO that holds the {addr, inst} pairs.
//   clk, rst_n   : clock and asynchronous active-low reset
//   flush        : synchronous empty (the contents are kept but ignored)
//   push, push_data
//   pop          : the head entry is removed when pop && !empty
//   head         : the head entry, read straight from the storage registers
//   full, empty, count
// The storage resets to RESET_VAL. The head therefore shows a defined
// word and address while the FIFO is empty after reset.
// DEPTH must be a power of two so that the pointers wrap on their own.
// ---------------------------------------------------------------------------
module enc_fifo #(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      // A simultaneous push and pop leave the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder: turns ALU operation descriptors into RV32I machine words.
// Each word is tagged with a sequential instruction address.
//   clk, rst_n : clock and asynchronous active-low reset
//   restart    : synchronous flush of the FIFO and the encode stage; it also
//                reloads the address counter with BASE_ADDR
//   bus        : inst_encoder_if.slave (descriptor in, word/address/err out)
// Pipeline: a one-cycle encode stage register feeds an enc_fifo of DEPTH
// entries. An illegal descriptor is dropped when it leaves the stage, and err
// pulses for one cycle.
// Build macro ENC_IMM_CHECK_EN: when it is defined, an immediate that does not
// fit its field makes the descriptor illegal. When it is undefined, the
// immediate is truncated to fit.
// ---------------------------------------------------------------------------
module inst_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  inst_encoder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ready_en_q;
  logic          stage_valid_q;
  logic          stage_illegal_q;
  logic [31:0]   stage_word_q;
  logic [31:0]   addr_q;
  logic          err_q;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ;
  logic          fifo_full;
  logic          fifo_empty;
  logic [63:0]   fifo_head;
  logic          in_ready;
  logic          accept;
  logic          push;
  logic          pop;
  enc_result_t   enc;

  function automatic enc_result_t encode(
    input logic [3:0]  code,
    input logic        uns,
    input logic        imm,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] immv
  );
    enc_result_t r;
    logic        imm12_ok;
    logic        shamt_ok;
    logic [2:0]  f3_slt;
    r.illegal = 1'b0;
    r.word    = NOP_WORD;
`ifdef ENC_IMM_CHECK_EN
    // The value lies in -2048..2047 exactly when bits 31..11 are all equal.
    imm12_ok = (immv[31:11] == '0) || (immv[31:11] == '1);
    shamt_ok = (immv[31:5] == '0);
`else
    imm12_ok = 1'b1;
    shamt_ok = 1'b1;
`endif
    f3_slt = uns ? F3_SLTU : F3_SLT;
    case (code)
      ALU_NOP: r.word = NOP_WORD;
      ALU_ADD: begin
        if (imm) begin
          r.word    = {immv[11:0], rs1, F3_ADD, rd, OPC_I};
          r.illegal = !imm12_ok;
        end else begin
          r.word = {F7_ZERO, rs2, rs1, F3_ADD, rd, OPC_R};
        end
      end
      ALU_SUB: begin
        if (imm) r.illegal = 1'b1;
        else     r.word    = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_R};
      end
      ALU_SLL: begin
        if (imm) begin
          r.word    = {7'b0, immv[4:0], rs1, F3_SLL, rd, OPC_I};
          r.illegal = !shamt_ok;
        end else begin
          r.word = {F7_ZERO, rs2, rs1, F3_SLL, rd, OPC_R};
        end
      end
      ALU_SLT: begin
        if (imm) begin
          r.word    = {immv[11:0], rs1, f3_slt, rd, OPC_I};
          r.illegal = !imm12_ok;
        end else begin
          r.word = {F7_ZERO, rs2, rs1, f3_slt, rd, OPC_R};
        end
      end
      ALU_XOR: begin
        if (imm) r.illegal = 1'b1;
        else     r.word    = {F7_ZERO, rs2, rs1, F3_XOR, rd, OPC_R};
      end
      default: r.illegal = 1'b1;
    endcase
    // nop is legal whatever its other fields are; only slt has an unsigned form.
    if (uns && (code != ALU_SLT) && (code != ALU_NOP)) r.illegal = 1'b1;
    return r;
  endfunction

  assign enc = encode(bus.alu_control, bus.is_unsigned, bus.is_imm,
                      bus.rd_num, bus.rs1_num, bus.rs2_num, bus.immSmall);

  // The word held in the stage is counted as occupancy, so the stage always
  // has a free FIFO slot. out_ready does not enter this path.
  assign occ      = fifo_count + CW'(stage_valid_q);
  assign in_ready = ready_en_q && !restart && (occ < CW'(DEPTH));
  assign accept   = bus.in_valid && in_ready;
  assign push     = stage_valid_q && !stage_illegal_q && !restart && !fifo_full;
  assign pop      = bus.out_ready && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q      <= 1'b0;
      stage_valid_q   <= 1'b0;
      stage_illegal_q <= 1'b0;
      stage_word_q    <= '0;
      addr_q          <= BASE_ADDR;
      err_q           <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      // A descriptor flushed by restart raises no err.
      err_q      <= stage_valid_q && stage_illegal_q && !restart;
      if (restart) begin
        stage_valid_q <= 1'b0;
        addr_q        <= BASE_ADDR;
      end else begin
        stage_valid_q <= accept;
        if (accept) begin
          stage_illegal_q <= enc.illegal;
          stage_word_q    <= enc.word;
        end
        if (push) addr_q <= addr_q + 32'd4;
      end
    end
  end

  enc_fifo #(
    .WIDTH     (64),
    .DEPTH     (DEPTH),
    .RESET_VAL ({BASE_ADDR, 32'h0})
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (restart),
    .push      (push),
    .push_data ({addr_q, stage_word_q}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.inst      = fifo_head[31:0];
  assign bus.inst_addr = fifo_head[63:32];
  assign bus.err       = err_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (BASE_ADDR 0, DEPTH 4). The expected words
// are computed by hand from the RV32I field layout.
module tb_inst_encoder;
  import enc_pkg::*;

  logic clk;
  logic rst_n;
  logic restart;
  int   checks;
  int   errors;
  logic [31:0] exp_addr;

  inst_encoder_if bus();

  inst_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [3:0] code, input logic uns, input logic imm,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] immv);
    int n = 0;
    while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_in_ready got=%b expected=1", bus.in_ready);
    end
    bus.alu_control = code; bus.is_unsigned = uns; bus.is_imm = imm;
    bus.rd_num = rd; bus.rs1_num = rs1; bus.rs2_num = rs2; bus.immSmall = immv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [31:0] ei, input logic [31:0] ea);
    int n = 0;
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.inst !== ei || bus.inst_addr !== ea) begin
      errors++;
      $display("FAIL %s valid=%b inst=%h addr=%h expected inst=%h addr=%h",
               name, bus.out_valid, bus.inst, bus.inst_addr, ei, ea);
    end else begin
      $display("PASS %s inst=%h addr=%h", name, bus.inst, bus.inst_addr);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; restart = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_control = ALU_NOP;
    bus.is_unsigned = 1'b0; bus.is_imm = 1'b0; bus.rd_num = '0; bus.rs1_num = '0;
    bus.rs2_num = '0; bus.immSmall = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.inst !== 32'h0 ||
        bus.inst_addr !== 32'h0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values rdy=%b vld=%b inst=%h addr=%h err=%b expected 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.inst, bus.inst_addr, bus.err);
    end else $display("PASS reset_values");
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got=%b expected=0", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge got=%b expected=1", bus.in_ready);
    end else $display("PASS ready_after_edge");
    exp_addr = 32'h0;
  endtask

  task automatic test_encode();
    send(ALU_ADD, 0, 0, 5'd3, 5'd1, 5'd2, 32'h0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early out_valid=%b expected=0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL latency_two out_valid=%b expected=1", bus.out_valid);
    end
    expect_word("add", 32'h002081B3, exp_addr); exp_addr += 4;
    send(ALU_SUB, 0, 0, 5'd5, 5'd6, 5'd7, 32'h0);
    expect_word("sub", 32'h407302B3, exp_addr); exp_addr += 4;
    send(ALU_ADD, 0, 1, 5'd1, 5'd0, 5'd9, 32'hFFFF_FFFF);
    expect_word("addi", 32'hFFF00093, exp_addr); exp_addr += 4;
    send(ALU_SLL, 0, 1, 5'd2, 5'd2, 5'd0, 32'd5);
    expect_word("slli", 32'h00511113, exp_addr); exp_addr += 4;
    send(ALU_SLT, 1, 1, 5'd4, 5'd1, 5'd0, 32'd10);
    expect_word("sltiu", 32'h00A0B213, exp_addr); exp_addr += 4;
    send(ALU_SLT, 0, 0, 5'd10, 5'd11, 5'd12, 32'h0);
    expect_word("slt", 32'h00C5A533, exp_addr); exp_addr += 4;
    send(ALU_XOR, 0, 0, 5'd1, 5'd2, 5'd3, 32'h0);
    expect_word("xor", 32'h003140B3, exp_addr); exp_addr += 4;
    send(ALU_SLT, 1, 0, 5'd1, 5'd2, 5'd3, 32'h0);
    expect_word("sltu", 32'h003130B3, exp_addr); exp_addr += 4;
    send(ALU_NOP, 0, 1, 5'd7, 5'd8, 5'd9, 32'h1234_5678);
    expect_word("nop", 32'h00000013, exp_addr); exp_addr += 4;
  endtask

  task automatic illegal_one(input string name, input logic [3:0] code, input logic uns,
                             input logic imm, input logic [31:0] immv);
    send(code, uns, imm, 5'd1, 5'd2, 5'd3, immv);
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s err=%b out_valid=%b expected err=1 out_valid=0", name, bus.err, bus.out_valid);
    end else $display("PASS %s err pulse", name);
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after err=%b out_valid=%b expected 0 0", name, bus.err, bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    illegal_one("xori_illegal", ALU_XOR, 0, 1, 32'h0);
    illegal_one("subi_illegal", ALU_SUB, 0, 1, 32'h0);
    illegal_one("unsigned_add", ALU_ADD, 1, 0, 32'h0);
    illegal_one("code_0011", 4'b0011, 0, 0, 32'h0);
    send(ALU_ADD, 0, 0, 5'd3, 5'd1, 5'd2, 32'h0);
    expect_word("after_illegal", 32'h002081B3, exp_addr); exp_addr += 4;
  endtask

  task automatic test_imm_range();
`ifdef ENC_IMM_CHECK_EN
    illegal_one("addi_2048", ALU_ADD, 0, 1, 32'd2048);
    illegal_one("slli_40", ALU_SLL, 0, 1, 32'd40);
    send(ALU_ADD, 0, 1, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
    expect_word("addi_m2048", 32'h80000093, exp_addr); exp_addr += 4;
`else
    send(ALU_ADD, 0, 1, 5'd0, 5'd0, 5'd0, 32'd2048);
    expect_word("addi_2048", 32'h80000013, exp_addr); exp_addr += 4;
    send(ALU_SLL, 0, 1, 5'd2, 5'd2, 5'd0, 32'd40);
    expect_word("slli_40", 32'h00811113, exp_addr); exp_addr += 4;
`endif
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic [31:0] words [6];
    logic [31:0] addrs [6];
    logic        acc;
    logic        pp;
    logic [31:0] base = exp_addr;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (c == 8) begin
        checks++;
        if (idx !== 4 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
            bus.inst !== 32'h00208033 || bus.inst_addr !== base) begin
          errors++;
          $display("FAIL hold_full accepted=%0d rdy=%b vld=%b inst=%h addr=%h expected 4 0 1 %h %h",
                   idx, bus.in_ready, bus.out_valid, bus.inst, bus.inst_addr, 32'h00208033, base);
        end else $display("PASS hold_full accepted=%0d", idx);
        bus.out_ready = 1'b1;
      end
      if (got == 6) break;
      bus.in_valid = (idx < 6); bus.alu_control = ALU_ADD; bus.is_unsigned = 1'b0;
      bus.is_imm = 1'b0; bus.rd_num = 5'(idx); bus.rs1_num = 5'd1; bus.rs2_num = 5'd2;
      acc = bus.in_valid && bus.in_ready;
      pp  = bus.out_valid && bus.out_ready;
      if (pp) begin words[got] = bus.inst; addrs[got] = bus.inst_addr; got++; end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL b2b_count got=%0d expected=6 after %0d cycles", got, cyc);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (words[i] !== (32'h00208033 | (32'(i) << 7)) || addrs[i] !== base + 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b_word%0d inst=%h addr=%h expected inst=%h addr=%h", i, words[i], addrs[i],
                 32'h00208033 | (32'(i) << 7), base + 32'(4 * i));
      end else $display("PASS b2b_word%0d inst=%h addr=%h", i, words[i], addrs[i]);
    end
    exp_addr = base + 32'd24;
  endtask

  task automatic test_restart();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(ALU_ADD, 0, 0, 5'd3, 5'd1, 5'd2, 32'h0);
    @(posedge clk); #1;
    restart = 1'b1; #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_ready rdy=%b vld=%b expected 0 1", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    restart = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL restart_flush out_valid=%b expected=0", bus.out_valid);
    end else $display("PASS restart_flush");
    // An illegal descriptor caught in the stage by restart must not raise err.
    send(ALU_XOR, 0, 1, 5'd1, 5'd2, 5'd3, 32'h0);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_stage err=%b vld=%b expected 0 0", bus.err, bus.out_valid);
    end
    exp_addr = 32'h0;
    send(ALU_ADD, 0, 0, 5'd3, 5'd1, 5'd2, 32'h0);
    expect_word("after_restart", 32'h002081B3, exp_addr); exp_addr += 4;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send(ALU_SUB, 0, 0, 5'd5, 5'd6, 5'd7, 32'h0);
    send(ALU_SUB, 0, 0, 5'd5, 5'd6, 5'd7, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.inst !== 32'h0 ||
        bus.inst_addr !== 32'h0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset rdy=%b vld=%b inst=%h addr=%h err=%b expected 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.inst, bus.inst_addr, bus.err);
    end else $display("PASS async_reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset rdy=%b vld=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
    exp_addr = 32'h0;
    send(ALU_ADD, 0, 1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    expect_word("after_reset", 32'hFFF00093, exp_addr); exp_addr += 4;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_encode();
    test_illegal();
    test_imm_range();
    test_back_to_back();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
